// File: rtl/module_bin_to_bcd_pkg.sv
// Shared types and constants for the double-dabble binary-to-BCD converter.
package bin_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGITS     = 4;
    localparam int SCRATCH_DIGITS = 5;
    localparam int BCD_W          = BCD_DIGITS * 4;
    localparam int SCRATCH_W      = SCRATCH_DIGITS * 4;

    localparam logic [BCD_W-1:0] OVF_CODE = 16'hFFFF;
    localparam int               MAX_DEC  = 9999;

endpackage

// File: rtl/module_bin_to_bcd_if.sv
// Start/result handshake between the product register, the converter and the display driver.
interface module_bin_to_bcd_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  start_i;
    logic [DATA_WIDTH-1:0] bin_i;
    logic                  busy_o;
    logic                  valid_o;
    logic [15:0]           bcd_o;
    logic                  ovf_o;
    logic                  neg_o;

    modport master (
        output start_i, bin_i,
        input  busy_o, valid_o, bcd_o, ovf_o, neg_o
    );

    modport slave (
        input  start_i, bin_i,
        output busy_o, valid_o, bcd_o, ovf_o, neg_o
    );
endinterface

// File: rtl/module_bin_to_bcd_add3.sv
// Single BCD digit corrector applied before each double-dabble shift.
module module_bcd_add3 (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);
    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
endmodule

// File: rtl/module_bin_to_bcd.sv
// Sequential double-dabble converter, one bit per clock, 5-digit scratch.
// Optional macro BIN2BCD_SIGNED_EN: treat bin_i as two's complement and report its sign.
module module_bin_to_bcd
    import bin_bcd_pkg::*;
#(
    parameter int DATA_WIDTH = 14
) (
    input  logic                clk_i,
    input  logic                rst_i,
    module_bin_to_bcd_if.slave  bus
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] mag;
    logic [SCRATCH_W-1:0]  scratch_q;
    logic [SCRATCH_W-1:0]  corrected;
    logic [4:0]            count_q;
    logic                  valid_q;
    logic [BCD_W-1:0]      bcd_q;
    logic                  ovf_q;
    logic                  scratch_ovf;

`ifdef BIN2BCD_SIGNED_EN
    logic neg_q;
    logic neg_out_q;

    // Negating the most negative value wraps to itself, which read unsigned is the right magnitude.
    assign mag = bus.bin_i[DATA_WIDTH-1] ? (~bus.bin_i + DATA_WIDTH'(1)) : bus.bin_i;
`else
    assign mag = bus.bin_i;
`endif

    for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_add3
        module_bcd_add3 u_add3 (
            .digit_in  (scratch_q[g*4 +: 4]),
            .digit_out (corrected[g*4 +: 4])
        );
    end

    assign scratch_ovf = (scratch_q[SCRATCH_W-1 -: 4] != 4'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = SHIFT;
            SHIFT:   if (count_q == 5'd1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shift_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            neg_q     <= 1'b0;
            neg_out_q <= 1'b0;
`endif
        end else begin
            valid_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        shift_q   <= mag;
                        scratch_q <= '0;
                        count_q   <= 5'(DATA_WIDTH);
`ifdef BIN2BCD_SIGNED_EN
                        neg_q     <= bus.bin_i[DATA_WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    // Correct digits first, then shift the binary MSB into the scratch LSB.
                    scratch_q <= {corrected[SCRATCH_W-2:0], shift_q[DATA_WIDTH-1]};
                    shift_q   <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                    count_q   <= count_q - 5'd1;
                end
                DONE: begin
                    ovf_q <= scratch_ovf;
                    bcd_q <= scratch_ovf ? OVF_CODE : scratch_q[BCD_W-1:0];
`ifdef BIN2BCD_SIGNED_EN
                    neg_out_q <= neg_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o  = (state_q == SHIFT);
    assign bus.valid_o = valid_q;
    assign bus.bcd_o   = bcd_q;
    assign bus.ovf_o   = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    assign bus.neg_o   = neg_out_q;
`else
    assign bus.neg_o   = 1'b0;
`endif

endmodule

// File: tb/tb_module_bin_to_bcd.sv
// Directed bench for module_bin_to_bcd with a queue scoreboard checked on every valid pulse.
module tb_module_bin_to_bcd;
    import bin_bcd_pkg::*;

    localparam int W = 14;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic        neg;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    module_bin_to_bcd_if #(.DATA_WIDTH(W)) bus ();

    module_bin_to_bcd #(.DATA_WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference conversion by integer division, independent of the shift-add algorithm.
    function automatic exp_t model(input logic [W-1:0] v, input int c);
        exp_t r;
        int   m;
`ifdef BIN2BCD_SIGNED_EN
        r.neg = v[W-1];
        m     = v[W-1] ? ((1 << W) - int'(v)) : int'(v);
`else
        r.neg = 1'b0;
        m     = int'(v);
`endif
        r.ovf = (m > MAX_DEC);
        r.bcd = r.ovf ? 16'hFFFF
                      : {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
        r.cyc = c;
        return r;
    endfunction

    // Called at a falling edge; the accept edge is the next rising edge.
    task automatic start_conv(input logic [W-1:0] v);
        bus.start_i = 1'b1;
        bus.bin_i   = v;
        sb.push_back(model(v, cyc + W + 2));
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid_o) break;
        end
        if (i == 40) check("valid_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.valid_o) begin
            check("busy_valid_excl", {31'd0, bus.busy_o}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_valid", {16'd0, bus.bcd_o}, 32'hDEAD);
            end else begin
                e = sb.pop_front();
                check("bcd",     {16'd0, bus.bcd_o}, {16'd0, e.bcd});
                check("ovf",     {31'd0, bus.ovf_o}, {31'd0, e.ovf});
                check("neg",     {31'd0, bus.neg_o}, {31'd0, e.neg});
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int busy_cnt;
        logic [W-1:0] extra [4];
        bus.start_i = 1'b0;
        bus.bin_i   = '0;

        #1;
        check("rst_busy",  {31'd0, bus.busy_o},  32'd0);
        check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("rst_bcd",   {16'd0, bus.bcd_o},   32'd0);
        check("rst_ovf",   {31'd0, bus.ovf_o},   32'd0);
        check("rst_neg",   {31'd0, bus.neg_o},   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic conversion and busy duration
        start_conv(W'(1234));
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            busy_cnt += int'(bus.busy_o);
            @(negedge clk);
        end
        check("busy_cycles", 32'(busy_cnt), 32'd14);
        wait_idle();

        // Back-to-back: second start in the valid cycle
        start_conv(W'(0));
        wait_valid();
        start_conv(W'(9999));
        wait_idle();

        // Out of range
        start_conv(W'(10000));
        wait_idle();
        start_conv(W'(16383));
        wait_idle();

        // Start while busy is ignored, and later bin_i changes have no effect
        start_conv(W'(42));
        repeat (3) @(negedge clk);
        bus.start_i = 1'b1;
        bus.bin_i   = W'(77);
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);

        // Mid-conversion reset discards the conversion
        start_conv(W'(5678));
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",  {31'd0, bus.busy_o},  32'd0);
        check("midrst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("midrst_bcd",   {16'd0, bus.bcd_o},   32'd0);
        check("midrst_ovf",   {31'd0, bus.ovf_o},   32'd0);
        check("midrst_neg",   {31'd0, bus.neg_o},   32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        start_conv(W'(5678));
        wait_idle();

        // Digit-boundary values
        extra[0] = W'(9);
        extra[1] = W'(10);
        extra[2] = W'(100);
        extra[3] = W'(8191);
        for (int i = 0; i < 4; i++) begin
            start_conv(extra[i]);
            wait_idle();
        end

`ifdef BIN2BCD_SIGNED_EN
        start_conv(14'h3FD6);
        wait_idle();
        start_conv(14'h2000);
        wait_idle();
        start_conv(W'(42));
        wait_idle();
`endif

        repeat (20) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
